// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter branch predictor with perf counters.
// Define BRANCH_PREDICTOR_BTB_EN to add per-entry valid/tag/target storage (BTB).
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_lookup_pc,
   output logic        o_pred_valid,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_target,
   output logic        o_init_busy,
   input  logic        i_upd_en,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target,
   output logic [31:0] o_br_cnt,
   output logic [31:0] o_mispred_cnt
);

   // state  | meaning
   // S_INIT | writing one table entry per cycle to weakly-not-taken; lookups/updates suppressed
   // S_RUN  | normal prediction and update
   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int DEPTH = 2 ** INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);
   localparam logic [INDEX_BITS-1:0] ONE_IDX  = INDEX_BITS'(1);
   localparam logic [31:0]           CNT_MAX  = 32'hFFFF_FFFF;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [INDEX_BITS-1:0] r_init_idx;
   logic [1:0]            r_ctr [DEPTH];
   logic [31:0]           r_br_cnt;
   logic [31:0]           r_mispred_cnt;

   logic                  w_run;
   logic                  w_in_init;
   logic                  w_upd_accept;
   logic                  w_pred_dir;
   logic                  w_mispred;
   logic [INDEX_BITS-1:0] w_lk_idx;
   logic [INDEX_BITS-1:0] w_up_idx;
   logic [1:0]            w_lk_ctr;
   logic [1:0]            w_up_ctr;
   logic [1:0]            w_up_ctr_nxt;
   logic                  w_unused;

   function automatic logic [1:0] f_sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == 2'b11) ? ctr : ctr + 2'b01;
      else
         return (ctr == 2'b00) ? ctr : ctr - 2'b01;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_INIT;
         r_init_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_INIT)
            r_init_idx <= r_init_idx + ONE_IDX;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (r_init_idx == LAST_IDX) w_state_nxt = S_RUN;
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_INIT;
      endcase
   end

   // Reset is folded in so outputs read as idle/busy while rst is held.
   assign w_run        = (r_state == S_RUN)  & ~i_rst;
   assign w_in_init    = (r_state == S_INIT) & ~i_rst;
   assign w_upd_accept = w_run & i_upd_en;
   assign o_init_busy  = ~w_run;

   assign w_lk_idx     = i_lookup_pc[INDEX_BITS+1:2];
   assign w_up_idx     = i_upd_pc[INDEX_BITS+1:2];
   assign w_lk_ctr     = r_ctr[w_lk_idx];
   assign w_up_ctr     = r_ctr[w_up_idx];
   assign w_up_ctr_nxt = f_sat_ctr(w_up_ctr, i_upd_taken);
   assign w_mispred    = i_upd_taken ^ w_pred_dir;

`ifdef BRANCH_PREDICTOR_BTB_EN
   logic                r_valid  [DEPTH];
   logic [TAG_BITS-1:0] r_tag    [DEPTH];
   logic [31:0]         r_target [DEPTH];

   logic [TAG_BITS-1:0] w_lk_tag;
   logic [TAG_BITS-1:0] w_up_tag;
   logic                w_lk_hit;
   logic                w_up_hit;

   assign w_lk_tag      = i_lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign w_up_tag      = i_upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign w_lk_hit      = r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
   assign w_up_hit      = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);

   assign o_pred_valid  = w_run & w_lk_hit;
   assign o_pred_taken  = o_pred_valid & w_lk_ctr[1];
   assign o_pred_target = o_pred_valid ? r_target[w_lk_idx] : 32'h0;
   assign w_pred_dir    = w_up_hit & w_up_ctr[1];

   // A not-taken miss leaves the entry alone so a live branch is not evicted by a fall-through.
   always_ff @(posedge i_clk) begin
      if (w_in_init) begin
         r_ctr[r_init_idx]   <= 2'b01;
         r_valid[r_init_idx] <= 1'b0;
      end else if (w_upd_accept) begin
         if (w_up_hit) begin
            r_ctr[w_up_idx] <= w_up_ctr_nxt;
            if (i_upd_taken)
               r_target[w_up_idx] <= i_upd_target;
         end else if (i_upd_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= i_upd_target;
            r_ctr[w_up_idx]    <= 2'b10;
         end
      end
   end

   assign w_unused = ^{i_lookup_pc[31:INDEX_BITS+TAG_BITS+2], i_lookup_pc[1:0],
                       i_upd_pc[31:INDEX_BITS+TAG_BITS+2], i_upd_pc[1:0]};
`else
   assign o_pred_valid  = w_run;
   assign o_pred_taken  = w_run & w_lk_ctr[1];
   assign o_pred_target = 32'h0;
   assign w_pred_dir    = w_up_ctr[1];

   always_ff @(posedge i_clk) begin
      if (w_in_init)
         r_ctr[r_init_idx] <= 2'b01;
      else if (w_upd_accept)
         r_ctr[w_up_idx] <= w_up_ctr_nxt;
   end

   assign w_unused = ^{i_lookup_pc[31:INDEX_BITS+2], i_lookup_pc[1:0],
                       i_upd_pc[31:INDEX_BITS+2], i_upd_pc[1:0], i_upd_target};
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_br_cnt      <= '0;
         r_mispred_cnt <= '0;
      end else if (w_upd_accept) begin
         if (r_br_cnt != CNT_MAX)
            r_br_cnt <= r_br_cnt + 32'd1;
         if (w_mispred && (r_mispred_cnt != CNT_MAX))
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end

   assign o_br_cnt      = r_br_cnt;
   assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a table-level behavioural model,
// plus hand-computed literal checks for init length, saturation and same-cycle behaviour.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lookup_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        init_busy;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [31:0] br_cnt;
   logic [31:0] mispred_cnt;

   int n_checks = 0;
   int n_errors = 0;

   branch_predictor dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_lookup_pc  (lookup_pc),
      .o_pred_valid (pred_valid),
      .o_pred_taken (pred_taken),
      .o_pred_target(pred_target),
      .o_init_busy  (init_busy),
      .i_upd_en     (upd_en),
      .i_upd_pc     (upd_pc),
      .i_upd_taken  (upd_taken),
      .i_upd_target (upd_target),
      .o_br_cnt     (br_cnt),
      .o_mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int          m_ctr [64];
   bit          m_val [64];
   int          m_tag [64];
   logic [31:0] m_tgt [64];
   int          init_left = 0;
   logic [31:0] m_br  = 0;
   logic [31:0] m_mis = 0;
   bit          known = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int next_ctr(input int c, input logic taken);
      if (taken) return (c + 1 > 3) ? 3 : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
   endfunction

   task automatic model_update();
      int i, t;
      bit pdir;
      i = int'((upd_pc >> 2) & 32'd63);
      t = int'((upd_pc >> 8) & 32'd255);
`ifdef BRANCH_PREDICTOR_BTB_EN
      begin
         bit hit;
         hit  = m_val[i] && (m_tag[i] == t);
         pdir = hit && (m_ctr[i] >= 2);
         if (hit) begin
            m_ctr[i] = next_ctr(m_ctr[i], upd_taken);
            if (upd_taken) m_tgt[i] = upd_target;
         end else if (upd_taken) begin
            m_val[i] = 1;
            m_tag[i] = t;
            m_tgt[i] = upd_target;
            m_ctr[i] = 2;
         end
      end
`else
      pdir = (m_ctr[i] >= 2);
      m_ctr[i] = next_ctr(m_ctr[i], upd_taken);
`endif
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if ((upd_taken != pdir) && (m_mis != 32'hFFFF_FFFF)) m_mis = m_mis + 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         known     = 1;
         init_left = 64;
         m_br      = 0;
         m_mis     = 0;
         for (int k = 0; k < 64; k++) begin
            m_ctr[k] = 1;
            m_val[k] = 0;
            m_tag[k] = 0;
            m_tgt[k] = 0;
         end
      end else if (init_left > 0) begin
         init_left = init_left - 1;
      end else if (upd_en) begin
         model_update();
      end
   end

   // Compare process: every cycle once the model state is defined by a reset.
   always @(negedge clk) begin
      if (known) begin
         bit          run, e_valid, e_taken;
         logic [31:0] e_tgt;
         int          li, lt;
         run = !rst && (init_left == 0);
         li  = int'((lookup_pc >> 2) & 32'd63);
         lt  = int'((lookup_pc >> 8) & 32'd255);
`ifdef BRANCH_PREDICTOR_BTB_EN
         e_valid = run && m_val[li] && (m_tag[li] == lt);
         e_taken = e_valid && (m_ctr[li] >= 2);
         e_tgt   = e_valid ? m_tgt[li] : 32'h0;
`else
         e_valid = run;
         e_taken = run && (m_ctr[li] >= 2);
         e_tgt   = 32'h0;
         if (lt < 0) e_tgt = 32'h1;
`endif
         chk("init_busy",   {31'h0, init_busy},  {31'h0, !run});
         chk("pred_valid",  {31'h0, pred_valid}, {31'h0, e_valid});
         chk("pred_taken",  {31'h0, pred_taken}, {31'h0, e_taken});
         chk("pred_target", pred_target, e_tgt);
         chk("br_cnt",      br_cnt, m_br);
         chk("mispred_cnt", mispred_cnt, m_mis);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_pc();
      logic [31:0] p;
      p       = $urandom;
      p[7:2]  = 6'($urandom_range(0, 7));
      p[15:8] = 8'($urandom_range(0, 2));
      return p;
   endfunction

   // Counts busy cycles while hammering upd_en; returns at the first non-busy negedge.
   task automatic count_busy(output int n);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         upd_en     = 1;
         upd_pc     = $urandom;
         upd_taken  = 1'($urandom);
         upd_target = $urandom;
         @(negedge clk);
         if (!init_busy) begin
            chk("br_zero_after_init", br_cnt, 32'h0);
            upd_en = 0;
            return;
         end
         if (pred_valid) chk("pred_valid_in_init", {31'h0, pred_valid}, 32'h0);
         n++;
         tick();
      end
      upd_en = 0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      upd_en     = 1;
      upd_pc     = pc;
      upd_taken  = taken;
      upd_target = tgt;
      tick();
      upd_en     = 0;
   endtask

   initial begin
      int n;
      rst = 1; upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; lookup_pc = 0;
      repeat (2) tick();
      rst = 0;

      // init length with updates offered throughout
      count_busy(n);
      chk("busy_cycles", n, 64);
      tick();

      // same-cycle update and lookup on idx 5: old entry seen, new entry next cycle
      lookup_pc = 32'h14;
      upd_en = 1; upd_pc = 32'h14; upd_taken = 1; upd_target = 32'h500;
      @(negedge clk);
      chk("same_cycle_old", {31'h0, pred_taken}, 32'h0);
      tick();
      upd_en = 0;
      @(negedge clk);
      chk("same_cycle_new", {31'h0, pred_taken}, 32'h1);
      tick();

      // pc 0x100: three taken, then four not-taken, then one taken from the floor
      lookup_pc = 32'h100;
      repeat (3) upd(32'h100, 1'b1, 32'h180);
      @(negedge clk);
      chk("t2_pred_taken", {31'h0, pred_taken}, 32'h1);
      chk("t2_br",  br_cnt, 32'd4);
      chk("t2_mis", mispred_cnt, 32'd2);
      tick();
      repeat (4) upd(32'h100, 1'b0, 32'h0);
      @(negedge clk);
      chk("t3_pred_taken", {31'h0, pred_taken}, 32'h0);
      chk("t3_br",  br_cnt, 32'd8);
      chk("t3_mis", mispred_cnt, 32'd4);
      tick();
      upd(32'h100, 1'b1, 32'h180);
      @(negedge clk);
      chk("t3_no_wrap", {31'h0, pred_taken}, 32'h0);
      chk("t3_mis2", mispred_cnt, 32'd5);
      tick();

`ifdef BRANCH_PREDICTOR_BTB_EN
      lookup_pc = 32'h2000;
      upd(32'h2000, 1'b1, 32'h2400);
      @(negedge clk);
      chk("t4_valid",  {31'h0, pred_valid}, 32'h1);
      chk("t4_taken",  {31'h0, pred_taken}, 32'h1);
      chk("t4_target", pred_target, 32'h2400);
      tick();
      lookup_pc = 32'h3000;
      @(negedge clk);
      chk("t4_alias_valid", {31'h0, pred_valid}, 32'h0);
      tick();
`else
      lookup_pc = 32'h2000;
      @(negedge clk);
      chk("t4_valid_nobtb",  {31'h0, pred_valid}, 32'h1);
      chk("t4_target_nobtb", pred_target, 32'h0);
      tick();
`endif

      // reset in the middle of init, then again in run
      rst = 1; tick(); rst = 0;
      repeat (30) tick();
      rst = 1; tick(); rst = 0;
      count_busy(n);
      chk("busy_after_mid_rst", n, 64);
      tick();
      repeat (5) upd(mk_pc(), 1'b1, $urandom);
      rst = 1;
      tick();
      @(negedge clk);
      chk("rst_run_br",  br_cnt, 32'h0);
      chk("rst_run_mis", mispred_cnt, 32'h0);
      tick();
      rst = 0;
      count_busy(n);
      chk("busy_after_run_rst", n, 64);
      tick();

      // randomized traffic with aliasing tags and occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 699) == 0);
         upd_en     = 1'($urandom);
         upd_pc     = mk_pc();
         upd_taken  = ($urandom_range(0, 3) != 0);
         upd_target = $urandom;
         lookup_pc  = ($urandom_range(0, 1) == 0) ? upd_pc : mk_pc();
         tick();
      end
      rst = 0; upd_en = 0;
      tick();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule
